// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared pcsel codes and FSM state encoding for fetch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_S1  = 2'b01;
    localparam logic [1:0] PCSEL_S2  = 2'b10;
    localparam logic [1:0] PCSEL_MP  = 2'b11;

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_HOLD  = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

endpackage
`default_nettype wire

// File: rtl/redirect_prio.sv
`default_nettype none
// ============================================================================
// Module      : redirect_prio
// Description : Fixed-priority pick among mispredict, slot 1 and slot 2.
// Revision    : 1.0 - initial release
// ============================================================================
module redirect_prio
    import fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             mp_valid,
    input  logic [WIDTH-1:0] mp_target,
    input  logic             s1_valid,
    input  logic [WIDTH-1:0] s1_target,
    input  logic             s2_valid,
    input  logic [WIDTH-1:0] s2_target,
    output logic             win_valid,
    output logic [1:0]       win_sel,
    output logic [WIDTH-1:0] win_target
);

    always_comb begin
        win_valid  = 1'b0;
        win_sel    = PCSEL_SEQ;
        win_target = '0;
        if (mp_valid) begin
            win_valid  = 1'b1;
            win_sel    = PCSEL_MP;
            win_target = mp_target;
        end else if (s1_valid) begin
            win_valid  = 1'b1;
            win_sel    = PCSEL_S1;
            win_target = s1_target;
        end else if (s2_valid) begin
            win_valid  = 1'b1;
            win_sel    = PCSEL_S2;
            win_target = s2_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_redirect_ctrl
// Description : Fetch PC source sequencer with stall buffering and timed squash.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallf,
    input  logic [WIDTH-1:0] pcplus8f,
    input  logic             redir1_valid,
    input  logic [WIDTH-1:0] redir1_target,
    input  logic             redir2_valid,
    input  logic [WIDTH-1:0] redir2_target,
    input  logic             mispred_valid,
    input  logic [WIDTH-1:0] mispred_pc,
    output logic [WIDTH-1:0] pcnext,
    output logic [1:0]       pcsel,
    output logic             redirect_taken,
    output logic             flushd,
    output logic             pending,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [1:0]       r_state;
    logic             r_pend_valid;
    logic [1:0]       r_pend_sel;
    logic [WIDTH-1:0] r_pend_target;
    logic [2:0]       r_flush_cnt;
    logic             r_flushd;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s1_valid;
    logic             w_s2_valid;
    logic             w_win_valid;
    logic [1:0]       w_win_sel;
    logic [WIDTH-1:0] w_win_target;
    logic             w_req_valid;
    logic [1:0]       w_req_sel;
    logic [WIDTH-1:0] w_req_target;
    logic             w_apply;

    // Decode slots only count in RUN; elsewhere they are re-presented or wrong-path.
    assign w_s1_valid = (r_state == c_ST_RUN) && redir1_valid;
    assign w_s2_valid = (r_state == c_ST_RUN) && redir2_valid;

    redirect_prio #(.WIDTH(WIDTH)) u_prio (
        .mp_valid   (mispred_valid),
        .mp_target  (mispred_pc),
        .s1_valid   (w_s1_valid),
        .s1_target  (redir1_target),
        .s2_valid   (w_s2_valid),
        .s2_target  (redir2_target),
        .win_valid  (w_win_valid),
        .win_sel    (w_win_sel),
        .win_target (w_win_target)
    );

    always_comb begin
        w_req_valid  = w_win_valid;
        w_req_sel    = w_win_sel;
        w_req_target = w_win_target;
        if (!mispred_valid && r_pend_valid) begin
            w_req_valid  = 1'b1;
            w_req_sel    = r_pend_sel;
            w_req_target = r_pend_target;
        end
        w_apply = w_req_valid && !stallf;
    end

    assign pcnext         = w_apply ? w_req_target : pcplus8f;
    assign pcsel          = w_apply ? w_req_sel : PCSEL_SEQ;
    assign redirect_taken = w_apply;
    assign flushd         = r_flushd;
    assign pending        = r_pend_valid;
    assign redirect_cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_RUN;
            r_pend_valid  <= 1'b0;
            r_pend_sel    <= PCSEL_SEQ;
            r_pend_target <= '0;
            r_flush_cnt   <= 3'd0;
            r_flushd      <= 1'b0;
            r_cnt         <= '0;
        end else begin
            if (w_apply) begin
                r_state       <= c_ST_FLUSH;
                r_flush_cnt   <= c_FLUSH_LOAD;
                r_flushd      <= 1'b1;
                r_pend_valid  <= 1'b0;
                r_pend_sel    <= PCSEL_SEQ;
                r_pend_target <= '0;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_req_valid) begin
                // Stalled: buffer the winner (a mispredict overwrites any older entry).
                r_pend_valid  <= 1'b1;
                r_pend_sel    <= w_req_sel;
                r_pend_target <= w_req_target;
                if (r_state == c_ST_RUN) begin
                    r_state <= c_ST_HOLD;
                end
            end else if (r_state == c_ST_FLUSH && !stallf) begin
                if (r_flush_cnt <= 3'd1) begin
                    r_state     <= c_ST_RUN;
                    r_flush_cnt <= 3'd0;
                    r_flushd    <= 1'b0;
                end else begin
                    r_flush_cnt <= r_flush_cnt - 3'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_redirect_ctrl
// Description : Directed scoreboard bench for fetch_redirect_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_ctrl;

    localparam int          c_FC = 2;
    localparam logic [31:0] c_P  = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stallf = 1'b0;
    logic [31:0] pcplus8f = c_P;
    logic        redir1_valid = 1'b0, redir2_valid = 1'b0, mispred_valid = 1'b0;
    logic [31:0] redir1_target = '0, redir2_target = '0, mispred_pc = '0;
    logic [31:0] pcnext, pcnext_s;
    logic [1:0]  pcsel, pcsel_s;
    logic        redirect_taken, flushd, pending;
    logic        redirect_taken_s, flushd_s, pending_s;
    logic [15:0] redirect_cnt;
    logic [2:0]  redirect_cnt_s;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  sel;
        logic        tk;
        logic        fl;
        logic        pd;
        logic [15:0] cnt;
        logic [2:0]  cs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(.WIDTH(32), .FLUSH_CYCLES(c_FC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stallf(stallf), .pcplus8f(pcplus8f),
        .redir1_valid(redir1_valid), .redir1_target(redir1_target),
        .redir2_valid(redir2_valid), .redir2_target(redir2_target),
        .mispred_valid(mispred_valid), .mispred_pc(mispred_pc),
        .pcnext(pcnext), .pcsel(pcsel), .redirect_taken(redirect_taken),
        .flushd(flushd), .pending(pending), .redirect_cnt(redirect_cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    fetch_redirect_ctrl #(.WIDTH(32), .FLUSH_CYCLES(c_FC), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .stallf(stallf), .pcplus8f(pcplus8f),
        .redir1_valid(redir1_valid), .redir1_target(redir1_target),
        .redir2_valid(redir2_valid), .redir2_target(redir2_target),
        .mispred_valid(mispred_valid), .mispred_pc(mispred_pc),
        .pcnext(pcnext_s), .pcsel(pcsel_s), .redirect_taken(redirect_taken_s),
        .flushd(flushd_s), .pending(pending_s), .redirect_cnt(redirect_cnt_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Target value 0 means "request not valid".
    task automatic step(input logic rs, input logic st,
                        input logic [31:0] t1, input logic [31:0] t2, input logic [31:0] mp,
                        input logic [31:0] e_pc, input logic [1:0] e_sel, input logic e_tk,
                        input logic e_fl, input logic e_pd, input int e_cnt, input int e_cs);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rs;
        stallf        = st;
        redir1_valid  = (t1 != 0);
        redir1_target = t1;
        redir2_valid  = (t2 != 0);
        redir2_target = t2;
        mispred_valid = (mp != 0);
        mispred_pc    = mp;
        e.pc  = e_pc;
        e.sel = e_sel;
        e.tk  = e_tk;
        e.fl  = e_fl;
        e.pd  = e_pd;
        e.cnt = 16'(e_cnt);
        e.cs  = 3'(e_cs);
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pcnext",         pcnext,                e.pc);
                chk("pcsel",          {30'd0, pcsel},        {30'd0, e.sel});
                chk("redirect_taken", {31'd0, redirect_taken}, {31'd0, e.tk});
                chk("flushd",         {31'd0, flushd},       {31'd0, e.fl});
                chk("pending",        {31'd0, pending},      {31'd0, e.pd});
                chk("redirect_cnt",   {16'd0, redirect_cnt}, {16'd0, e.cnt});
                chk("redirect_cnt_sat", {29'd0, redirect_cnt_s}, {29'd0, e.cs});
            end
        end
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        // Idle after reset
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 0, 0, 0, 0);
        // Slot1 beats slot2, flush lasts c_FC cycles
        step(0, 0, 32'h400, 32'h800, 0, 32'h400, 2'b01, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 0, 0, 1, 1);
        // Slot2 under stall, applied on release
        step(0, 1, 0, 32'h800, 0, c_P, 2'b00, 0, 0, 0, 1, 1);
        step(0, 1, 0, 32'h800, 0, c_P, 2'b00, 0, 0, 1, 1, 1);
        step(0, 1, 0, 32'h800, 0, c_P, 2'b00, 0, 0, 1, 1, 1);
        step(0, 0, 0, 32'h800, 0, 32'h800, 2'b10, 1, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 1, 0, 2, 2);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 1, 0, 2, 2);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 0, 0, 2, 2);
        // Mispredict overwrites a pending slot1 in HOLD
        step(0, 1, 32'h400, 0, 0, c_P, 2'b00, 0, 0, 0, 2, 2);
        step(0, 1, 32'h400, 0, 32'h2000, c_P, 2'b00, 0, 0, 1, 2, 2);
        step(0, 0, 32'h400, 0, 0, 32'h2000, 2'b11, 1, 0, 1, 2, 2);
        // FLUSH: slot ignored, mispredict applied and flush extended
        step(0, 0, 32'h500, 0, 0, c_P, 2'b00, 0, 1, 0, 3, 3);
        step(0, 0, 0, 0, 32'h3000, 32'h3000, 2'b11, 1, 1, 0, 3, 3);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 1, 0, 4, 4);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 1, 0, 4, 4);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 0, 0, 4, 4);
        // FLUSH: stalled mispredict buffered, counter frozen, applied on release
        step(0, 0, 32'h600, 0, 0, 32'h600, 2'b01, 1, 0, 0, 4, 4);
        step(0, 1, 0, 0, 32'h4000, c_P, 2'b00, 0, 1, 0, 5, 5);
        step(0, 1, 0, 0, 0, c_P, 2'b00, 0, 1, 1, 5, 5);
        step(0, 0, 0, 0, 0, 32'h4000, 2'b11, 1, 1, 1, 5, 5);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 1, 0, 6, 6);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 1, 0, 6, 6);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 0, 0, 6, 6);
        // Two more redirects: narrow counter saturates at 7
        step(0, 0, 32'h700, 0, 0, 32'h700, 2'b01, 1, 0, 0, 6, 6);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 1, 0, 7, 7);
        step(0, 0, 0, 0, 32'h5000, 32'h5000, 2'b11, 1, 1, 0, 7, 7);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 1, 0, 8, 7);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 1, 0, 8, 7);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 0, 0, 8, 7);
        // Reset while in HOLD with a pending redirect
        step(0, 1, 0, 32'h900, 0, c_P, 2'b00, 0, 0, 0, 8, 7);
        step(0, 1, 0, 32'h900, 0, c_P, 2'b00, 0, 0, 1, 8, 7);
        step(1, 1, 0, 32'h900, 0, c_P, 2'b00, 0, 0, 1, 8, 7);
        step(0, 1, 0, 0, 0, c_P, 2'b00, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, c_P, 2'b00, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
